timer_mmio_slave: RTL and testbench

//  Memory-mapped timer/counter that responds to the core's memory-map bus.
//  It sits beside data_memory and uart_IP as a slave, driven by the map_Data, map_Address and WSel/HSel strobes.
//  It provides a prescaled 32-bit up-counter, a compare register, optional auto-reload, sticky status flags and an irq level.

---
 rtl/timer_mmio_slave.sv | 120 ++++++++++++
 tb/tb_timer_mmio_slave.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_mmio_slave.sv
// Memory-mapped prescaled timer: 32-bit up-counter with compare match, optional
// auto-reload, sticky MATCH/OVERRUN status (write-1-to-clear) and a level irq.
module timer_mmio_slave #(
    parameter int                     DATA_WIDTH  = 32,
    parameter int                     PRESC_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0]  COMPARE_RST = {DATA_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [31:0]           address,
    input  logic                  we,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rd,
    output logic                  irq
);

    localparam logic [DATA_WIDTH-1:0]  CNT_ONE   = 1;
    localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = 1;

    localparam logic [2:0] A_CTRL     = 3'd0;
    localparam logic [2:0] A_PRESCALE = 3'd1;
    localparam logic [2:0] A_COMPARE  = 3'd2;
    localparam logic [2:0] A_COUNT    = 3'd3;
    localparam logic [2:0] A_STATUS   = 3'd4;

    logic [2:0]             ctrl_q,   ctrl_d;
    logic [PRESC_WIDTH-1:0] presc_q,  presc_d;
    logic [DATA_WIDTH-1:0]  cmp_q,    cmp_d;
    logic [DATA_WIDTH-1:0]  cnt_q,    cnt_d;
    logic [1:0]             status_q, status_d;
    logic [PRESC_WIDTH-1:0] pcnt_q,   pcnt_d;

    logic [2:0] sel;
    logic       wr_ctrl, wr_presc, wr_cmp, wr_cnt, wr_status;
    logic       en, tick, match_ev;
    logic       unused_addr;

    assign sel         = address[4:2];
    assign unused_addr = ^{address[31:5], address[1:0]};

    assign wr_ctrl   = we && (sel == A_CTRL);
    assign wr_presc  = we && (sel == A_PRESCALE);
    assign wr_cmp    = we && (sel == A_COMPARE);
    assign wr_cnt    = we && (sel == A_COUNT);
    assign wr_status = we && (sel == A_STATUS);

    // Tick and match use pre-edge state, so clearing EN on a tick edge still counts.
    assign en       = ctrl_q[0];
    assign tick     = en && (pcnt_q == presc_q);
    assign match_ev = tick && !wr_cnt && (cnt_q == cmp_q);

    always_comb begin
        ctrl_d   = ctrl_q;
        presc_d  = presc_q;
        cmp_d    = cmp_q;
        cnt_d    = cnt_q;
        status_d = status_q;
        pcnt_d   = pcnt_q;

        if (wr_ctrl)  ctrl_d  = wd[2:0];
        if (wr_presc) presc_d = wd[PRESC_WIDTH-1:0];
        if (wr_cmp)   cmp_d   = wd;

        if (wr_presc || wr_cnt) begin
            pcnt_d = '0;
        end else if (en) begin
            pcnt_d = tick ? '0 : pcnt_q + PRESC_ONE;
        end

        // A bus write to COUNT overrides any tick on the same edge.
        if (wr_cnt) begin
            cnt_d = wd;
        end else if (tick) begin
            if (match_ev && ctrl_q[1]) cnt_d = '0;
            else                       cnt_d = cnt_q + CNT_ONE;
        end

        if (wr_status) status_d = status_q & ~wd[1:0];
        if (match_ev) begin
            status_d[0] = 1'b1;
            if (status_q[0]) status_d[1] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q   <= '0;
            presc_q  <= '0;
            cmp_q    <= COMPARE_RST;
            cnt_q    <= '0;
            status_q <= '0;
            pcnt_q   <= '0;
        end else begin
            ctrl_q   <= ctrl_d;
            presc_q  <= presc_d;
            cmp_q    <= cmp_d;
            cnt_q    <= cnt_d;
            status_q <= status_d;
            pcnt_q   <= pcnt_d;
        end
    end

    always_comb begin
        rd = '0;
        if (re) begin
            case (sel)
                A_CTRL:     rd[2:0]             = ctrl_q;
                A_PRESCALE: rd[PRESC_WIDTH-1:0] = presc_q;
                A_COMPARE:  rd                  = cmp_q;
                A_COUNT:    rd                  = cnt_q;
                A_STATUS:   rd[1:0]             = status_q;
                default:    rd                  = '0;
            endcase
        end
    end

    assign irq = status_q[0] & ctrl_q[2];

endmodule

// File: tb/tb_timer_mmio_slave.sv
// Scoreboard bench for timer_mmio_slave: expected values are queued when a
// read is issued and popped when the combinational read data is sampled.
module tb_timer_mmio_slave;

    logic        clk;
    logic        rst;
    logic [31:0] wd;
    logic [31:0] address;
    logic        we;
    logic        re;
    logic [31:0] rd;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];

    localparam logic [31:0] O_CTRL   = 32'h00;
    localparam logic [31:0] O_PRESC  = 32'h04;
    localparam logic [31:0] O_CMP    = 32'h08;
    localparam logic [31:0] O_CNT    = 32'h0C;
    localparam logic [31:0] O_STATUS = 32'h10;

    timer_mmio_slave #(
        .DATA_WIDTH (32),
        .PRESC_WIDTH(16),
        .COMPARE_RST(32'hFFFF_FFFF)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wd     (wd),
        .address(address),
        .we     (we),
        .re     (re),
        .rd     (rd),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        address = addr;
        wd      = data;
        we      = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic expect_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        exp_t e;
        exp_t got;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
        address = addr;
        re      = 1'b1;
        #1;
        got = sb_q.pop_front();
        chk_val(got.tag, rd, got.exp);
        re = 1'b0;
    endtask

    task automatic expect_irq(input string tag, input logic exp);
        exp_t e;
        exp_t got;
        e.tag = tag;
        e.exp = {31'b0, exp};
        sb_q.push_back(e);
        #1;
        got = sb_q.pop_front();
        chk_val(got.tag, {31'b0, irq}, got.exp);
    endtask

    initial begin
        logic [31:0] rst_vals [8];
        rst  = 1'b1;
        wd   = '0;
        address = '0;
        we   = 1'b0;
        re   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state of every offset
        rst_vals = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 8; i++)
            expect_rd($sformatf("rst_off%0d", i), 32'(i * 4), rst_vals[i]);
        expect_irq("rst_irq", 1'b0);
        address = O_CMP;
        re      = 1'b0;
        #1;
        chk_val("re0_rd", rd, 32'h0);

        // Prescale 3, compare 5, irq enabled
        bus_wr(O_PRESC, 32'd3);
        bus_wr(O_CMP,   32'd5);
        bus_wr(O_CNT,   32'd0);
        bus_wr(O_CTRL,  32'd7);
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            expect_rd($sformatf("pre_cnt%0d", k), O_CNT, (k == 24) ? 32'd0 : 32'(k / 4));
            if (k == 23) expect_rd("pre_st23", O_STATUS, 32'd0);
            if (k == 24) begin
                expect_rd("pre_st24", O_STATUS, 32'd1);
                expect_irq("pre_irq24", 1'b1);
            end
        end

        // W1C behaviour with counter stopped
        bus_wr(O_CTRL, 32'd4);
        bus_wr(O_STATUS, 32'd0);
        expect_rd("w1c_zero", O_STATUS, 32'd1);
        expect_irq("w1c_irq_on", 1'b1);
        bus_wr(O_STATUS, 32'd1);
        expect_rd("w1c_one", O_STATUS, 32'd0);
        expect_irq("w1c_irq_off", 1'b0);

        // Wrap through FFFFFFFF with compare at all ones
        bus_wr(O_CTRL,  32'd0);
        bus_wr(O_PRESC, 32'd0);
        bus_wr(O_CMP,   32'hFFFF_FFFF);
        bus_wr(O_CNT,   32'hFFFF_FFFE);
        bus_wr(O_CTRL,  32'd1);
        @(posedge clk); #1;
        expect_rd("wrap_c1", O_CNT, 32'hFFFF_FFFF);
        expect_rd("wrap_s1", O_STATUS, 32'd0);
        @(posedge clk); #1;
        expect_rd("wrap_c2", O_CNT, 32'h0);
        expect_rd("wrap_s2", O_STATUS, 32'd1);
        @(posedge clk); #1;
        expect_rd("wrap_c3", O_CNT, 32'h1);
        expect_rd("wrap_s3", O_STATUS, 32'd1);

        // Collision: W1C on the match edge
        bus_wr(O_CTRL,   32'd0);
        bus_wr(O_STATUS, 32'd3);
        bus_wr(O_CMP,    32'd3);
        bus_wr(O_CNT,    32'd2);
        bus_wr(O_CTRL,   32'd1);
        @(posedge clk);
        bus_wr(O_STATUS, 32'd1);
        expect_rd("col_w1c_st", O_STATUS, 32'd1);
        expect_rd("col_w1c_cnt", O_CNT, 32'd4);

        // Second match while MATCH set raises OVERRUN
        bus_wr(O_CTRL, 32'd0);
        bus_wr(O_CNT,  32'd3);
        bus_wr(O_CTRL, 32'd1);
        @(posedge clk); #1;
        expect_rd("col_ovr_st", O_STATUS, 32'd3);
        expect_rd("col_ovr_cnt", O_CNT, 32'd4);
        bus_wr(O_CTRL, 32'd0);
        bus_wr(O_STATUS, 32'd2);
        expect_rd("ovr_clr", O_STATUS, 32'd1);

        // COUNT write on a tick edge wins
        bus_wr(O_CMP,  32'd1000);
        bus_wr(O_CTRL, 32'd1);
        bus_wr(O_CNT,  32'd10);
        expect_rd("col_cntwr", O_CNT, 32'd10);
        @(posedge clk); #1;
        expect_rd("col_cntwr_nx", O_CNT, 32'd11);

        // Async reset mid-run
        bus_wr(O_CTRL,  32'd0);
        bus_wr(O_PRESC, 32'd2);
        bus_wr(O_CNT,   32'd7);
        bus_wr(O_CTRL,  32'd7);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        expect_rd("arst_ctrl",  O_CTRL,   32'd0);
        expect_rd("arst_presc", O_PRESC,  32'd0);
        expect_rd("arst_cmp",   O_CMP,    32'hFFFF_FFFF);
        expect_rd("arst_cnt",   O_CNT,    32'd0);
        expect_rd("arst_st",    O_STATUS, 32'd0);
        expect_irq("arst_irq", 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bus_wr(O_PRESC, 32'd2);
        bus_wr(O_CTRL,  32'd1);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            expect_rd($sformatf("arst_run%0d", k), O_CNT, (k == 3) ? 32'd1 : 32'd0);
        end

        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
